// File: rtl/aes_encrypt_core.sv
// aes_encrypt_core: AES-128 forward-round sequencer and state register with start/done handshake.
// Define AES_ENC_ABORT_EN to abort a run when AES_START drops before DONE.
module aes_encrypt_core #(
  parameter int KEYEXP_CYCLES = 12
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          AES_START,
  input  logic [127:0]  AES_MSG_PLAIN,
  input  logic [1407:0] RoundKeyArr,
  input  logic [127:0]  Sub_in,
  input  logic [127:0]  Shift_in,
  input  logic [31:0]   MixCol_in,
  output logic [127:0]  State_out,
  output logic [31:0]   Curr_Column_out,
  output logic [127:0]  AES_MSG_ENC,
  output logic          AES_DONE,
  output logic [3:0]    Round_out
);
  typedef enum logic [3:0] {
    HALTED, KEY_WAIT, ARK0, SUB_LOOP, SHIFT_LOOP, MIX0, MIX1, MIX2, MIX3,
    ARK_LOOP, SUB_FINAL, SHIFT_FINAL, ARK_FINAL, DONE
  } state_t;
  state_t st, nx;
  logic [127:0] s, s_nx, key;
  logic [3:0] r, r_nx, w, w_nx;
  logic [1:0] c;
  logic mix;
  assign key = (r > 4'd10) ? RoundKeyArr[127:0] : RoundKeyArr[128*r +: 128];
  assign mix = st inside {MIX0, MIX1, MIX2, MIX3};
  assign c = st == MIX1 ? 2'd1 : st == MIX2 ? 2'd2 : st == MIX3 ? 2'd3 : 2'd0;
  assign State_out = s;
  assign AES_MSG_ENC = s;
  assign AES_DONE = st == DONE;
  assign Round_out = r;
  assign Curr_Column_out = mix ? s[32*(3-c) +: 32] : 32'd0;
  always_comb begin
    nx = st;
    s_nx = s;
    r_nx = r;
    w_nx = w;
    if (mix) s_nx[32*(3-c) +: 32] = MixCol_in;
    case (st)
      HALTED:      nx = AES_START ? KEY_WAIT : HALTED;
      KEY_WAIT:    begin
        w_nx = w + 4'd1;
        nx = (w == 4'(KEYEXP_CYCLES - 1)) ? ARK0 : KEY_WAIT;
      end
      ARK0:        begin
        s_nx = AES_MSG_PLAIN ^ key;
        r_nx = 4'd1;
        nx = SUB_LOOP;
      end
      SUB_LOOP:    begin s_nx = Sub_in; nx = SHIFT_LOOP; end
      SHIFT_LOOP:  begin s_nx = Shift_in; nx = MIX0; end
      MIX0:        nx = MIX1;
      MIX1:        nx = MIX2;
      MIX2:        nx = MIX3;
      MIX3:        nx = ARK_LOOP;
      ARK_LOOP:    begin
        s_nx = s ^ key;
        r_nx = r + 4'd1;
        nx = (r == 4'd9) ? SUB_FINAL : SUB_LOOP;
      end
      SUB_FINAL:   begin s_nx = Sub_in; nx = SHIFT_FINAL; end
      SHIFT_FINAL: begin s_nx = Shift_in; nx = ARK_FINAL; end
      ARK_FINAL:   begin s_nx = s ^ key; nx = DONE; end
      DONE:        nx = AES_START ? DONE : HALTED;
      default:     nx = HALTED;
    endcase
`ifdef AES_ENC_ABORT_EN
    if (!AES_START && st != HALTED && st != DONE) begin
      nx = HALTED;
      s_nx = '0;
    end
`endif
    // Counters are zero whenever HALTED is entered so the next run starts clean
    if (nx == HALTED) begin
      r_nx = '0;
      w_nx = '0;
    end
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      st <= HALTED;
      s <= '0;
      r <= '0;
      w <= '0;
    end else begin
      st <= nx;
      s <= s_nx;
      r <= r_nx;
      w <= w_nx;
    end
  end
endmodule

// File: tb/tb_aes_encrypt_core.sv
// tb_aes_encrypt_core: drives aes_encrypt_core with behavioural AES units and checks every cycle of each run.
module tb_aes_encrypt_core;
  localparam int K = 12;
  localparam int TD = K + 68;
  logic CLK = 0, RESET = 1, AES_START = 0;
  logic [127:0] AES_MSG_PLAIN = '0;
  logic [1407:0] RoundKeyArr = '0;
  logic [127:0] Sub_in, Shift_in, State_out, AES_MSG_ENC;
  logic [31:0] MixCol_in, Curr_Column_out;
  logic AES_DONE;
  logic [3:0] Round_out;
  int n_tests = 0, n_fail = 0, t = 0;
  bit trk = 0;
  logic [127:0] last = '0;
  logic [127:0] es[100];
  logic [3:0] er[100];
  logic [31:0] ec[100];
  bit ed[100];

  aes_encrypt_core #(.KEYEXP_CYCLES(K)) dut (
    .CLK(CLK), .RESET(RESET), .AES_START(AES_START), .AES_MSG_PLAIN(AES_MSG_PLAIN),
    .RoundKeyArr(RoundKeyArr), .Sub_in(Sub_in), .Shift_in(Shift_in), .MixCol_in(MixCol_in),
    .State_out(State_out), .Curr_Column_out(Curr_Column_out), .AES_MSG_ENC(AES_MSG_ENC),
    .AES_DONE(AES_DONE), .Round_out(Round_out)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] gm(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from first principles: GF(2^8) inverse as x^254, then the affine map
  function automatic logic [7:0] sbox(logic [7:0] x);
    logic [7:0] q = x, y = 8'h01;
    for (int i = 1; i < 8; i++) begin
      q = gm(q, q);
      y = gm(y, q);
    end
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(logic [127:0] v);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(v[8*i +: 8]);
    return o;
  endfunction

  // FIPS byte k lives at bits [8*(15-k) +: 8]; state[r][c] is byte r+4c
  function automatic logic [127:0] shift_rows(logic [127:0] v);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[8*(15-(r+4*c)) +: 8] = v[8*(15-(r+4*((c+r)%4))) +: 8];
    return o;
  endfunction

  function automatic logic [31:0] mix_col(logic [31:0] v);
    logic [7:0] a[4];
    logic [31:0] o;
    for (int i = 0; i < 4; i++) a[i] = v[8*(3-i) +: 8];
    for (int i = 0; i < 4; i++)
      o[8*(3-i) +: 8] = gm(a[i], 8'h02) ^ gm(a[(i+1)%4], 8'h03) ^ a[(i+2)%4] ^ a[(i+3)%4];
    return o;
  endfunction

  function automatic logic [1407:0] expand(logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] tw;
    logic [7:0] rc = 8'h01;
    logic [1407:0] o;
    for (int i = 0; i < 4; i++) w[i] = key[32*(3-i) +: 32];
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {sbox(tw[23:16]), sbox(tw[15:8]), sbox(tw[7:0]), sbox(tw[31:24])} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int r = 0; r < 11; r++) o[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return o;
  endfunction

  assign Sub_in = sub_bytes(State_out);
  assign Shift_in = shift_rows(State_out);
  assign MixCol_in = mix_col(Curr_Column_out);

  // Expected outputs for each cycle t after the start cycle, from the FIPS-197 round order
  task automatic build(logic [127:0] pt, logic [127:0] prev);
    logic [127:0] v = pt ^ RoundKeyArr[127:0];
    int x = K + 2;
    for (int i = 0; i < 100; i++) begin es[i] = prev; er[i] = 4'd0; ec[i] = 32'd0; ed[i] = 0; end
    for (int rnd = 1; rnd <= 10; rnd++) begin
      es[x] = v; er[x] = 4'(rnd); x++; v = sub_bytes(v);
      es[x] = v; er[x] = 4'(rnd); x++; v = shift_rows(v);
      if (rnd < 10)
        for (int c = 0; c < 4; c++) begin
          es[x] = v; er[x] = 4'(rnd); ec[x] = v[32*(3-c) +: 32]; x++;
          v[32*(3-c) +: 32] = mix_col(v[32*(3-c) +: 32]);
        end
      es[x] = v; er[x] = 4'(rnd); x++; v ^= RoundKeyArr[128*rnd +: 128];
    end
    es[x] = v; er[x] = 4'd10; ed[x] = 1;
  endtask

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d actual=%h required=%h", nm, t, act, exp);
    end
  endtask

  // Per-cycle compare against the model while a run is being tracked
  task automatic step();
    @(negedge CLK);
    if (trk) begin
      chk("state", State_out, es[t]);
      chk("round", 128'(Round_out), 128'(er[t]));
      chk("column", 128'(Curr_Column_out), 128'(ec[t]));
      chk("done", 128'(AES_DONE), 128'(ed[t]));
      if (ed[t]) chk("enc", AES_MSG_ENC, es[t]);
      t++;
      if (t > TD) trk = 0;
    end
  endtask

  task automatic prep(logic [127:0] key, logic [127:0] pt);
    RoundKeyArr = expand(key);
    AES_MSG_PLAIN = pt;
    build(pt, last);
  endtask

  task automatic begin_run();
    AES_START = 1;
    t = 1;
    trk = 1;
  endtask

  task automatic go();
    begin_run();
    while (trk) step();
    last = es[TD];
  endtask

  task automatic drop();
    AES_START = 0;
    step();
    chk("drop_done", 128'(AES_DONE), 128'd0);
    chk("drop_round", 128'(Round_out), 128'd0);
    chk("drop_keep", AES_MSG_ENC, last);
  endtask

  task automatic wait_round(logic [3:0] rr);
    int n = 0;
    while (Round_out != rr && n < 200) begin step(); n++; end
    chk("wait_round", 128'(Round_out), 128'(rr));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    step();
    step();
    chk("rst_state", State_out, 128'd0);
    chk("rst_enc", AES_MSG_ENC, 128'd0);
    chk("rst_done", 128'(AES_DONE), 128'd0);
    chk("rst_round", 128'(Round_out), 128'd0);
    chk("rst_col", 128'(Curr_Column_out), 128'd0);
    RESET = 0;
    step();
    step();
    // FIPS-197 C.1 with the start held well past DONE
    prep(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff);
    chk("pin_c1_ct", es[TD], 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    go();
    chk("c1_ct", AES_MSG_ENC, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_done", 128'(AES_DONE), 128'd1);
      chk("hold_round", 128'(Round_out), 128'd10);
      chk("hold_state", State_out, last);
    end
    drop();
    step();
    chk("halt_keep", State_out, last);
    // FIPS-197 App. B, with the ARK0 result and the last round key pinned
    prep(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734);
    chk("pin_b_ark0", es[K+2], 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    chk("pin_b_key10", RoundKeyArr[1407:1280], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("pin_b_ct", es[TD], 128'h3925841d02dc09fbdc118597196a0b32);
    go();
    chk("b_ct", AES_MSG_ENC, 128'h3925841d02dc09fbdc118597196a0b32);
    drop();
    for (int k = 0; k < 3; k++) begin
      prep({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
      go();
      drop();
    end
    // Asynchronous reset while in round 5, landing on a MIX cycle
    prep(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff);
    begin_run();
    wait_round(4'd5);
    step();
    step();
    trk = 0;
    #1 RESET = 1;
    #1;
    chk("arst_state", State_out, 128'd0);
    chk("arst_enc", AES_MSG_ENC, 128'd0);
    chk("arst_round", 128'(Round_out), 128'd0);
    chk("arst_col", 128'(Curr_Column_out), 128'd0);
    chk("arst_done", 128'(AES_DONE), 128'd0);
    AES_START = 0;
    step();
    RESET = 0;
    last = '0;
    step();
    prep(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff);
    go();
    chk("post_rst_ct", AES_MSG_ENC, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    drop();
    // Start dropped during round 3
    prep(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734);
    begin_run();
    wait_round(4'd3);
    AES_START = 0;
`ifdef AES_ENC_ABORT_EN
    begin
      bit seen = 0;
      trk = 0;
      step();
      chk("abort_state", State_out, 128'd0);
      chk("abort_round", 128'(Round_out), 128'd0);
      for (int i = 0; i < 90; i++) begin step(); seen |= AES_DONE; end
      chk("abort_no_done", 128'(seen), 128'd0);
      last = '0;
    end
`else
    while (trk) step();
    last = es[TD];
    chk("nodrop_ct", AES_MSG_ENC, 128'h3925841d02dc09fbdc118597196a0b32);
    step();
    chk("nodrop_halt", 128'(AES_DONE), 128'd0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_encrypt_core.md
# aes_encrypt_core

- AES-128 encryption sequencer and state register: the forward counterpart of the Lab 9 decryption core.
- Consumes the precomputed 11-entry round-key array and drives external combinational SubBytes, ShiftRows and single-column MixColumns units.
- Applies the FIPS-197 forward round order.
- Presents the ciphertext with a start/done handshake toward the Avalon interface layer.

## Interface
- KEYEXP_CYCLES, 12, cycles spent in KEY_WAIT for the external key expansion to settle (1..15)
- CLK  in  1  clock; all state changes on rising edge
- RESET  in  1  asynchronous, active-high reset
- AES_START  in  1  start request; level, held high until AES_DONE seen
- AES_MSG_PLAIN  in  128  plaintext, stable while AES_START high
- RoundKeyArr  in  1408  round key r at bits [128r+127:128r], r=0..10
- Sub_in  in  128  SubBytes(State_out) from external unit
- Shift_in  in  128  ShiftRows(State_out) from external unit
- MixCol_in  in  32  MixColumns(Curr_Column_out) from external unit
- State_out  out  128  current state register
- Curr_Column_out  out  32  column presented to MixColumns
- AES_MSG_ENC  out  128  ciphertext; equals State_out, valid while AES_DONE high
- AES_DONE  out  1  encryption complete
- Round_out  out  4  current round counter (0..10)

## Operation
- State register S, round counter R (4 bits), wait counter W (4 bits).
- Column c (0..3) maps to S[127-32c:96-32c]; column 0 is the MSB word.
- FSM states and transitions:
  - HALTED: R=0, W=0. If AES_START, go to KEY_WAIT.
  - KEY_WAIT: W increments each cycle. When W==KEYEXP_CYCLES-1, go to ARK0.
  - ARK0: S <= AES_MSG_PLAIN ^ key0; R <= 1.
  - SUB_LOOP: S <= Sub_in. Then SHIFT_LOOP: S <= Shift_in.
  - MIX0..MIX3: Curr_Column_out = column c; column c of S <= MixCol_in. Curr_Column_out is 0 outside MIX states.
  - ARK_LOOP: S <= S ^ key R. If R==9, go to SUB_FINAL; else go to SUB_LOOP. R increments either way.
  - SUB_FINAL: S <= Sub_in. SHIFT_FINAL: S <= Shift_in. ARK_FINAL: S <= S ^ key10 (no MixColumns).
  - DONE: AES_DONE=1. Stay while AES_START high; go to HALTED when it is low.
- S is written only in ARK0, the SUB/SHIFT/MIX/ARK states and the finals. HALTED retains S so the last ciphertext stays readable.
- Key select out of range (R>10) selects key 0. This is unreachable in normal operation.

## Timing
- Reset values: S=0, R=0, W=0, FSM=HALTED, AES_DONE=0, AES_MSG_ENC=0, Curr_Column_out=0, Round_out=0.
- RESET asserted mid-operation returns to HALTED immediately and clears S.
- Cycle 0 is the cycle AES_START is sampled high in HALTED. Counting from it:
  - KEY_WAIT occupies cycles 1..KEYEXP_CYCLES.
  - ARK0 is at KEYEXP_CYCLES+1.
  - 9 rounds × 7 cycles follow.
  - The 3 final cycles follow.
  - AES_DONE first high at cycle KEYEXP_CYCLES+68, i.e. 80 at default.
- AES_DONE is a Moore output of DONE. It drops the cycle after AES_START is sampled low.
- AES_START high in DONE does not retrigger; a new run requires START low then high.
- AES_START low before DONE has no effect (run completes), unless AES_ENC_ABORT_EN is defined.
- External units are combinational on State_out: each step completes in one cycle, and each result is registered at the end of its cycle.

## Configuration
- AES_ENC_ABORT_EN defined:
  - AES_START sampled low in any state other than HALTED or DONE forces HALTED on the next edge.
  - In that case S is cleared to 0, R=0 and W=0.
  - AES_DONE is never asserted for an aborted run.
- Not defined: AES_START is ignored after leaving HALTED until the DONE state.

## Test plan
- FIPS-197 App. C.1, AES_START held high:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f with bench-precomputed RoundKeyArr, plaintext 00112233445566778899aabbccddeeff.
  - Required: AES_DONE first high at cycle 80; AES_MSG_ENC=69c4e0d86a7b0430d8cdb78070b4c55a.
- FIPS-197 App. B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734.
  - Required: ciphertext 3925841d02dc09fbdc118597196a0b32.
  - Required: after ARK0, State_out=193de3bea0f4e22b9ac68d2ae9f84808.
- Handshake:
  - Hold AES_START 5 cycles past DONE: AES_DONE stays 1 and there is no restart.
  - Drop AES_START: AES_DONE=0 next cycle and the FSM returns to HALTED.
  - AES_MSG_ENC keeps the ciphertext.
- Asynchronous reset in round 5 (Round_out=5):
  - Required: all outputs 0 without waiting for a clock edge.
  - Required: a following start produces the correct ciphertext in 80 cycles.
- Column order in MIX0..MIX3:
  - Required: Curr_Column_out equals S[127:96], S[95:64], S[63:32], S[31:0] in sequence.
  - Required: Curr_Column_out=0 in every other state.
- AES_START drop during round 3:
  - With AES_ENC_ABORT_EN: HALTED next cycle, S=0, no AES_DONE.
  - Without it: ciphertext is produced at cycle 80.
